sfq_pulse_tx: RTL and testbench

- Clocked transmitter that drives a toggle-encoded SFQ pulse line; every transition on `out` is one pulse, the same encoding our JTL and gate timing models consume.
- Pulse bursts are queued as commands. Each burst has a pulse count and an inter-pulse gap; the block enforces a minimum gap so downstream cells never see a critical-timing violation.
- It counts pulses returned on a loopback toggle line and flags any mismatch between pulses sent and pulses returned.
- Sits at the digital-to-SFQ boundary of test harnesses and chip-level wrappers, upstream of JTL chains.

---
 rtl/sfq_tx_pkg.sv | 24 ++
 rtl/sfq_cmd_fifo.sv | 53 +++++
 rtl/sfq_pulse_tx.sv | 179 +++++++++++++++++
 tb/tb_sfq_pulse_tx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfq_tx_pkg.sv
// Shared types and default parameters for the SFQ pulse transmitter.
// The command struct describes one burst at the default field widths.
package sfq_tx_pkg;

    localparam int CNT_W_DEF      = 8;
    localparam int GAP_W_DEF      = 8;
    localparam int MIN_GAP_DEF    = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;
    localparam int TOTAL_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        WAIT,
        DRAIN
    } tx_state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [GAP_W_DEF-1:0] gap;
    } cmd_t;

endpackage

// File: rtl/sfq_cmd_fifo.sv
// Synchronous command queue with wrap-bit pointers; the head entry is read
// combinationally so the FSM can pop it the cycle after it was pushed.
module sfq_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sfq_pulse_tx.sv
// Toggle-encoded SFQ pulse burst transmitter with queued commands, a minimum
// inter-pulse gap, and loopback pulse counting with mismatch detection.
module sfq_pulse_tx
    import sfq_tx_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int GAP_W      = GAP_W_DEF,
    parameter int MIN_GAP    = MIN_GAP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic [GAP_W-1:0]   cmd_gap,
    output logic               out,
    input  logic               ret_in,
    output logic               busy,
    output logic               done,
    output logic [TOTAL_W-1:0] sent_total,
    output logic [TOTAL_W-1:0] ret_total,
    output logic               err_mismatch
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    tx_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   rem_reg, rem_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [GAP_W-1:0]   gcnt_reg, gcnt_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic               out_reg, out_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic [TOTAL_W-1:0] sent_reg, sent_next;
    logic [TOTAL_W-1:0] ret_total_reg;

    logic               ret_sync1_reg, ret_sync2_reg, ret_prev_reg;
    logic               ret_edge;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W+GAP_W-1:0] fifo_dout;
    logic [CNT_W-1:0]   head_count;
    logic [GAP_W-1:0]   head_gap;
    logic [GAP_W-1:0]   eff_gap;

    sfq_cmd_fifo #(
        .WIDTH (CNT_W + GAP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .din   ({cmd_count, cmd_gap}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign head_count = fifo_dout[GAP_W +: CNT_W];
    assign head_gap   = fifo_dout[GAP_W-1:0];
    assign eff_gap    = (head_gap < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : head_gap;

    assign cmd_ready    = !fifo_full;
    assign out          = out_reg;
    assign done         = done_reg;
    assign err_mismatch = err_reg;
    assign sent_total   = sent_reg;
    assign ret_total    = ret_total_reg;
    assign busy         = (state_reg != IDLE) || !fifo_empty;

    // Loopback: two-flop synchronizer, then a delay flop for any-edge detection.
    assign ret_edge = ret_sync2_reg ^ ret_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_sync1_reg <= 1'b0;
            ret_sync2_reg <= 1'b0;
            ret_prev_reg  <= 1'b0;
            ret_total_reg <= '0;
        end else begin
            ret_sync1_reg <= ret_in;
            ret_sync2_reg <= ret_sync1_reg;
            ret_prev_reg  <= ret_sync2_reg;
            if (ret_edge) begin
                ret_total_reg <= ret_total_reg + TOTAL_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        gap_next   = gap_reg;
        gcnt_next  = gcnt_reg;
        timer_next = timer_reg;
        out_next   = out_reg;
        sent_next  = sent_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        fifo_pop   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        rem_next   = head_count;
                        gap_next   = eff_gap;
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                out_next  = ~out_reg;
                sent_next = sent_reg + TOTAL_W'(1);
                rem_next  = rem_reg - CNT_W'(1);
                if (rem_reg == CNT_W'(1)) begin
                    timer_next = '0;
                    state_next = DRAIN;
                end else if (gap_reg == GAP_W'(1)) begin
                    state_next = EMIT;
                end else begin
                    // EMIT itself accounts for one cycle of the gap.
                    gcnt_next  = gap_reg - GAP_W'(1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                gcnt_next = gcnt_reg - GAP_W'(1);
                if (gcnt_reg <= GAP_W'(1)) begin
                    state_next = EMIT;
                end
            end
            DRAIN: begin
                timer_next = timer_reg + TW'(1);
                if (ret_total_reg == sent_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            gap_reg   <= '0;
            gcnt_reg  <= '0;
            timer_reg <= '0;
            out_reg   <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            sent_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            gap_reg   <= gap_next;
            gcnt_reg  <= gcnt_next;
            timer_reg <= timer_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            sent_reg  <= sent_next;
        end
    end

endmodule

// File: tb/tb_sfq_pulse_tx.sv
// Scoreboard bench for sfq_pulse_tx: stimulus queues expected burst outcomes,
// a monitor checks pulse spacing, latency and counters at every done strobe.
module tb_sfq_pulse_tx;
    import sfq_tx_pkg::*;

    localparam int MIN_GAP = MIN_GAP_DEF;
    localparam int TIMEOUT = TIMEOUT_DEF;
    localparam int DEPTH   = FIFO_DEPTH_DEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_count = '0;
    logic [7:0]  cmd_gap = '0;
    logic        cmd_ready, out, ret_in, busy, done, err_mismatch;
    logic [15:0] sent_total, ret_total;

    always #5 clk = ~clk;

    sfq_pulse_tx dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .cmd_gap      (cmd_gap),
        .out          (out),
        .ret_in       (ret_in),
        .busy         (busy),
        .done         (done),
        .sent_total   (sent_total),
        .ret_total    (ret_total),
        .err_mismatch (err_mismatch)
    );

    // Loopback: out delayed two cycles; when echo is off the line freezes.
    bit   echo = 1'b1;
    logic lb_d1 = 1'b0;
    logic lb_line = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            lb_d1   <= 1'b0;
            lb_line <= 1'b0;
        end else begin
            lb_d1 <= out;
            if (echo) lb_line <= lb_d1;
        end
    end
    assign ret_in = lb_line;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    typedef struct {
        int          count;
        int          gap;
        int          acc;
        bit          idle_start;
        bit          timeout;
        bit          err;
        logic [15:0] sent;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_sent = '0;
    logic [15:0] m_ret  = '0;
    bit          m_err  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    function automatic cmd_t mk(input int n, input int g);
        cmd_t c;
        c.count = 8'(n);
        c.gap   = 8'(g);
        return c;
    endfunction

    // Called at a negedge; leaves cmd_valid high so callers can stream commands.
    task automatic push_cmd(input cmd_t c);
        exp_t e;
        int   budget = 400;
        cmd_valid = 1'b1;
        cmd_count = c.count;
        cmd_gap   = c.gap;
        while (!cmd_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e.count      = int'(c.count);
        e.gap        = (int'(c.gap) < MIN_GAP) ? MIN_GAP : int'(c.gap);
        e.acc        = cyc + 1;
        e.idle_start = !busy;
        m_sent       = m_sent + 16'(c.count);
        if (echo) m_ret = m_ret + 16'(c.count);
        e.sent       = m_sent;
        e.ret        = m_ret;
        e.timeout    = (c.count != 0) && (m_ret != m_sent);
        m_err        = m_err | e.timeout;
        e.err        = m_err;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int budget = 3000;
        while ((busy || sb.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Monitor: a toggle belongs to the burst at the head of the scoreboard.
    initial begin
        logic prev_out;
        int   tog;
        int   last_t;
        prev_out = 1'b0;
        tog      = 0;
        last_t   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_out = out;
                tog      = 0;
                continue;
            end
            if (out !== prev_out) begin
                prev_out = out;
                if (sb.size() == 0) begin
                    check("unexpected_toggle", 1, 0);
                end else begin
                    tog++;
                    if (tog == 1) begin
                        if (sb[0].idle_start) check("first_pulse_latency", cyc - sb[0].acc, 2);
                    end else begin
                        check("pulse_spacing", cyc - last_t, sb[0].gap);
                    end
                    if (tog > sb[0].count) check("excess_toggle", tog, sb[0].count);
                end
                last_t = cyc;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_done++;
                    $display("done %0d: cyc=%0d count=%0d gap=%0d pulses=%0d sent=%0d ret=%0d err=%0d",
                             n_done, cyc, e.count, e.gap, tog, sent_total, ret_total, err_mismatch);
                    check("pulse_count", tog, e.count);
                    check("err_mismatch", int'(err_mismatch), int'(e.err));
                    check("sent_total", int'(sent_total), int'(e.sent));
                    check("ret_total", int'(ret_total), int'(e.ret));
                    if (e.count == 0) begin
                        // done occupies the cycle that closes two edges after acceptance
                        if (e.idle_start) check("zero_cmd_done_latency", cyc - e.acc, 1);
                    end else if (e.timeout) begin
                        check("drain_timeout_len", cyc - last_t, TIMEOUT);
                    end else begin
                        check("drain_len_bounded",
                              int'((cyc - last_t) >= 1 && (cyc - last_t) <= 12), 1);
                    end
                end
                tog = 0;
            end
        end
    end

    initial begin
        int  seen;
        int  budget;
        bit  ready_dropped;
        logic last_out;

        repeat (3) @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_mismatch), 0);
        check("rst_sent", int'(sent_total), 0);
        check("rst_ret", int'(ret_total), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(cmd_ready), 1);

        // Basic burst, zero count, gap clamp
        push_cmd(mk(3, 5));
        cmd_valid = 1'b0;
        wait_idle();
        push_cmd(mk(0, 9));
        cmd_valid = 1'b0;
        wait_idle();
        push_cmd(mk(4, 0));
        cmd_valid = 1'b0;
        wait_idle();
        push_cmd(mk(3, 1));
        cmd_valid = 1'b0;
        wait_idle();

        // Lost pulses: even count so the frozen line matches out afterwards
        echo = 1'b0;
        push_cmd(mk(2, 3));
        cmd_valid = 1'b0;
        wait_idle();
        echo = 1'b1;
        repeat (4) @(negedge clk);
        push_cmd(mk(1, 2));
        cmd_valid = 1'b0;
        wait_idle();
        check("err_sticky", int'(err_mismatch), 1);

        // Full queue with cmd_valid held
        ready_dropped = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(mk(1, 3));
            if (!ready_dropped && !cmd_ready) begin
                ready_dropped = 1'b1;
                check("accepted_before_full", i + 1, DEPTH + 1);
            end
        end
        cmd_valid = 1'b0;
        check("ready_dropped", int'(ready_dropped), 1);
        wait_idle();

        // Reset after the third toggle of a long burst
        push_cmd(mk(10, 4));
        cmd_valid = 1'b0;
        seen     = 0;
        budget   = 200;
        last_out = out;
        while (seen < 3 && budget > 0) begin
            @(negedge clk);
            if (out !== last_out) seen++;
            last_out = out;
            budget--;
        end
        check("three_toggles_seen", seen, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        m_sent = '0;
        m_ret  = '0;
        m_err  = 1'b0;
        check("midrst_out", int'(out), 0);
        check("midrst_sent", int'(sent_total), 0);
        check("midrst_ret", int'(ret_total), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err_mismatch), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        push_cmd(mk(1, 0));
        cmd_valid = 1'b0;
        wait_idle();

        // Randomized streaming with intermittent valid
        for (int i = 0; i < 24; i++) begin
            push_cmd(mk($urandom_range(0, 5), $urandom_range(0, 6)));
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 15)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        check("final_sent", int'(sent_total), int'(m_sent));
        check("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(60000 * 10);
        bad++;
        $display("FAIL watchdog: got timeout expected completion (cyc %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
